bram_stream_reader: RTL and testbench

BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

---
 rtl/bram_stream_reader.sv | 154 +++++++++++++++
 tb/tb_bram_stream_reader.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/bram_stream_reader.sv
// Reads len consecutive 32-bit words from a BRAM port and streams them out
// through a 2-entry skid FIFO with valid/ready handshaking.
module bram_stream_reader #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      base_addr,
  input  logic [LEN_W-1:0] len,
  output logic             bram_en,
  output logic [3:0]       bram_we,
  output logic [31:0]      bram_addr,
  input  logic [31:0]      bram_rdata,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [31:0]      m_data,
  output logic             m_last,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] count
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  state_t           state_q, state_d;
  logic [29:0]      addr_q, addr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] issued_q, issued_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic             inflight_q, inflight_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       occ_q, occ_d;
  logic             done_q, done_d;
  logic [31:0]      mem_q [2];

  logic             issue, push, pop;
  logic [2:0]       room;
  logic             unused_base;

  assign unused_base = &{1'b0, base_addr[1:0]};

  assign m_valid   = (occ_q != 2'd0);
  assign m_data    = m_valid ? mem_q[rd_ptr_q] : 32'd0;
  assign m_last    = m_valid && (count_q == (len_q - ONE));
  assign bram_en   = issue;
  assign bram_we   = 4'b0000;
  assign bram_addr = {addr_q, 2'b00};
  assign busy      = (state_q == S_RUN);
  assign done      = done_q;
  assign count     = count_q;

  // Entries held plus the read still in flight must leave room after this cycle's pop.
  assign pop   = m_valid && m_ready;
  assign push  = (state_q == S_RUN) && inflight_q && !abort;
  assign room  = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue = (state_q == S_RUN) && !abort && (issued_q < len_q) && (room < 3'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      occ_q      <= 2'd0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      done_q     <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bram_rdata;
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    issued_d   = issued_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    done_d     = done_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len != '0) begin
            addr_d     = base_addr[31:2];
            len_d      = len;
            issued_d   = '0;
            count_d    = '0;
            done_d     = 1'b0;
            inflight_d = 1'b0;
            wr_ptr_d   = 1'b0;
            rd_ptr_d   = 1'b0;
            occ_d      = 2'd0;
            state_d    = S_RUN;
          end else begin
            count_d = '0;
            done_d  = 1'b1;
          end
        end
      end

      S_RUN: begin
        inflight_d = issue;
        if (issue) begin
          addr_d   = addr_q + 30'd1;
          issued_d = issued_q + ONE;
        end
        if (push) wr_ptr_d = ~wr_ptr_q;
        if (pop) begin
          rd_ptr_d = ~rd_ptr_q;
          count_d  = count_q + ONE;
        end
        occ_d = occ_q + {1'b0, push} - {1'b0, pop};

        // Abort wins over completion; an accepted word in that cycle still counts.
        if (abort) begin
          occ_d      = 2'd0;
          inflight_d = 1'b0;
          state_d    = S_IDLE;
        end else if (pop && m_last) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Table-driven plus randomized bench for bram_stream_reader; a cycle monitor
// checks every read address and every streamed word against a word-index model.
module tb_bram_stream_reader;

  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [31:0]      base_addr = '0;
  logic [LEN_W-1:0] len = '0;
  logic             bram_en;
  logic [3:0]       bram_we;
  logic [31:0]      bram_addr;
  logic [31:0]      bram_rdata = '0;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [31:0]      m_data;
  logic             m_last;
  logic             busy;
  logic             done;
  logic [LEN_W-1:0] count;

  bram_stream_reader #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .base_addr(base_addr), .len(len),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_rdata(bram_rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .done(done), .count(count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: transfer is a list of word indices 0..len-1.
  logic [31:0] salt;
  logic [31:0] exp_base = '0;
  int          exp_len = 0;
  int          issued = 0;
  int          acc = 0;
  bit          mon_en = 1'b0;
  bit          prev_v = 1'b0, prev_r = 1'b0, prev_last = 1'b0;
  logic [31:0] prev_data = '0;
  int          xfer_edges = 0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ salt ^ (a * 32'd2654435761);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  always @(posedge clk) if (bram_en) bram_rdata <= word_at(bram_addr);

  always @(negedge clk) begin
    if (mon_en) begin
      chk("we_zero", {28'd0, bram_we}, 32'd0);
      if (!busy) begin
        chk("idle_valid", {31'd0, m_valid}, 32'd0);
        chk("idle_en", {31'd0, bram_en}, 32'd0);
      end else begin
        chk("count_track", {16'd0, count}, acc);
      end
      if (prev_v && !prev_r && busy) begin
        chk("stall_valid", {31'd0, m_valid}, 32'd1);
        chk("stall_data", m_data, prev_data);
        chk("stall_last", {31'd0, m_last}, {31'd0, prev_last});
      end
      if (bram_en) begin
        chk("rd_addr", bram_addr, exp_base + 32'(4 * issued));
        chk("over_issue", {31'd0, issued < exp_len}, 32'd1);
        issued++;
      end
      if (m_valid && m_ready) begin
        chk("data", m_data, word_at(exp_base + 32'(4 * acc)));
        chk("last", {31'd0, m_last}, {31'd0, acc == exp_len - 1});
        acc++;
      end
      chk("fifo_depth", {31'd0, (issued - acc) <= 2}, 32'd1);
    end
    prev_v = m_valid; prev_r = m_ready; prev_data = m_data; prev_last = m_last;
  end

  task automatic chk_reset_vals();
    chk("rst_en", {31'd0, bram_en}, 32'd0);
    chk("rst_addr", bram_addr, 32'd0);
    chk("rst_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_last", {31'd0, m_last}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_count", {16'd0, count}, 32'd0);
    chk("rst_data", m_data, 32'd0);
  endtask

  task automatic do_xfer(input logic [31:0] b, input int n, input int rdy,
                         input int abort_after, input bit rst_mid);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; len = LEN_W'(n);
    @(posedge clk); #1;
    start = 1'b0; base_addr = $urandom; len = LEN_W'($urandom_range(1, 50));
    exp_base = {b[31:2], 2'b00}; exp_len = n; issued = 0; acc = 0;
    xfer_edges = 0;
    if (n == 0) begin
      @(negedge clk);
      chk("len0_done", {31'd0, done}, 32'd1);
      chk("len0_busy", {31'd0, busy}, 32'd0);
      repeat (3) @(negedge clk);
      return;
    end
    m_ready = ($urandom_range(99) < rdy);
    @(negedge clk);
    chk("lat_first_rd", {31'd0, bram_en}, 32'd1);
    @(posedge clk); #1; m_ready = ($urandom_range(99) < rdy);
    @(negedge clk);
    chk("lat_valid_e1", {31'd0, m_valid}, 32'd0);
    @(posedge clk); #1; m_ready = ($urandom_range(99) < rdy);
    @(negedge clk);
    chk("lat_valid_e2", {31'd0, m_valid}, 32'd1);
    xfer_edges = 2;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      xfer_edges++;
      start = 1'b0;
      if (!busy) return;
      if (rst_mid && issued >= 4) begin
        rst = 1'b1; start = 1'b1; abort = 1'b1; mon_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        chk_reset_vals();
        issued = 0; acc = 0; exp_len = 0;
        mon_en = 1'b1;
        repeat (4) @(negedge clk);
        return;
      end
      if (abort_after >= 0 && acc == abort_after) begin
        m_ready = 1'b0; abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_valid", {31'd0, m_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        return;
      end
      start = ($urandom_range(4) == 0);
      len = LEN_W'($urandom_range(1, 50));
      m_ready = ($urandom_range(99) < rdy);
    end
    errors++;
    $display("FAIL timeout actual=busy required=idle");
  endtask

  typedef struct {
    logic [31:0] base;
    int          n;
    int          rdy;
    int          abort_after;
    int          exp_count;
    bit          exp_done;
  } vec_t;

  vec_t vt[7];

  initial begin
    salt = $urandom;
    vt[0] = '{32'h0000_0100, 4,  100, -1, 4, 1'b1};
    vt[1] = '{32'hFFFF_FFF8, 4,  100, -1, 4, 1'b1};
    vt[2] = '{32'h0000_0200, 8,  50,  -1, 8, 1'b1};
    vt[3] = '{32'h0000_0000, 0,  100, -1, 0, 1'b1};
    vt[4] = '{32'h0000_1000, 16, 100, 5,  5, 1'b0};
    vt[5] = '{32'h0000_0040, 2,  100, -1, 2, 1'b1};
    vt[6] = '{32'h0000_0003, 3,  30,  -1, 3, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals();
    rst = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 7; i++) begin
      do_xfer(vt[i].base, vt[i].n, vt[i].rdy, vt[i].abort_after, 1'b0);
      chk("end_done", {31'd0, done}, {31'd0, vt[i].exp_done});
      chk("end_busy", {31'd0, busy}, 32'd0);
      if (vt[i].n != 0) chk("end_count", {16'd0, count}, vt[i].exp_count);
      if (vt[i].n != 0 && vt[i].rdy == 100 && vt[i].abort_after < 0)
        chk("throughput", xfer_edges, vt[i].n + 2);
    end

    for (int i = 0; i < 10; i++) begin
      int n;
      n = $urandom_range(1, 20);
      do_xfer($urandom, n, $urandom_range(20, 100), -1, 1'b0);
      chk("rnd_done", {31'd0, done}, 32'd1);
      chk("rnd_count", {16'd0, count}, n);
      chk("rnd_acc", acc, n);
    end

    do_xfer(32'h0000_0500, 10, 100, -1, 1'b1);
    chk("post_rst_done", {31'd0, done}, 32'd0);
    do_xfer(32'h0000_0600, 3, 60, -1, 1'b0);
    chk("after_rst_done", {31'd0, done}, 32'd1);
    chk("after_rst_count", {16'd0, count}, 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
